// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and helpers for the 4-way round-robin mux arbiter.
package mux_arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  // One-hot grant vector for a given mux select.
  function automatic logic [N_REQ-1:0] onehot_of(input logic [SEL_W-1:0] sel);
    onehot_of = N_REQ'(1) << sel;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant/mux-control bundle between the four sources, the arbiter and the consumer.
interface mux4_rr_arbiter_if;

  logic [mux_arb_pkg::N_REQ-1:0] req;
  logic [mux_arb_pkg::N_REQ-1:0] last;
  logic                          out_ready;
  logic [mux_arb_pkg::N_REQ-1:0] gnt;
  logic [mux_arb_pkg::SEL_W-1:0] sel;
  logic                          out_valid;
  logic                          busy;

  // Environment side: sources and consumer.
  modport master (
    output req, last, out_ready,
    input  gnt, sel, out_valid, busy
  );

  // Arbiter side.
  modport slave (
    input  req, last, out_ready,
    output gnt, sel, out_valid, busy
  );

endinterface

// File: rtl/mux4_rr_arbiter_pick4.sv
// Combinational rotating-priority picker: first set req bit scanning ptr, ptr+1, ... mod 4.
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Scan from the far end back to ptr so the nearest candidate wins.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one mux4to1 datapath between four bursting requesters.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  mux4_rr_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             found;
  logic [SEL_W-1:0] pick_idx;
  logic             busy;
  logic             out_valid;
  logic             xfer;
  logic [CNT_W-1:0] cnt_inc;

  rr_pick4 u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .found (found),
    .idx   (pick_idx)
  );

  assign busy      = (state_q == GRANT);
  assign out_valid = busy & bus.req[sel_q];
  assign xfer      = out_valid & bus.out_ready;
  assign cnt_inc   = cnt_q + CNT_W'(1);

  // State and grant registers; reset drops any in-flight burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: arbitrate in IDLE, count beats and detect release in GRANT.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          sel_d   = pick_idx;
          gnt_d   = onehot_of(pick_idx);
          cnt_d   = '0;
        end
      end
      GRANT: begin
        // Abandon, last beat and burst cap all release the same way.
        if (!bus.req[sel_q] ||
            (xfer && (bus.last[sel_q] || cnt_inc == CNT_W'(MAX_BURST)))) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = sel_q + SEL_W'(1);
          cnt_d   = '0;
        end else if (xfer) begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.busy      = busy;
  assign bus.out_valid = out_valid;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter (MAX_BURST = 8).
module tb_mux4_rr_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passes = 0;

  mux4_rr_arbiter_if bus ();

  mux4_rr_arbiter #(.MAX_BURST(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    logic [3:0] rot [8];
    int beats;
    rot = '{4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};

    // Reset held two cycles with all requests asserted.
    rst = 1'b1; bus.req = 4'hF; bus.last = 4'h0; bus.out_ready = 1'b0;
    tick(); tick();
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_sel", 32'(bus.sel), 32'h0);

    // Rotation with every beat marked last.
    rst = 1'b0; bus.last = 4'hF; bus.out_ready = 1'b1;
    tick();
    chk("first_gnt", 32'(bus.gnt), 32'h1);
    chk("first_valid", 32'(bus.out_valid), 32'h1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("rot_gnt_%0d", i), 32'(bus.gnt), 32'(rot[i]));
    end

    // Burst cap: only req[1]; last on other requesters must be ignored.
    bus.req = 4'b0010; bus.last = 4'b1101;
    tick();
    chk("cap_pre_idle", 32'(bus.gnt), 32'h0);
    tick();
    chk("cap_gnt", 32'(bus.gnt), 32'h2);
    chk("cap_sel", 32'(bus.sel), 32'h1);
    beats = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.busy && bus.out_valid && bus.out_ready) beats++;
      tick();
      if (!bus.busy) break;
    end
    chk("cap_beats", 32'(beats), 32'd8);
    chk("cap_release", 32'(bus.gnt), 32'h0);
    tick();
    chk("cap_regrant", 32'(bus.gnt), 32'h2);

    // Stall: grant 0100, one beat, then out_ready low for five cycles.
    bus.req = 4'b0100; bus.last = 4'h0;
    tick();
    chk("stall_pre_idle", 32'(bus.gnt), 32'h0);
    tick();
    chk("stall_gnt", 32'(bus.gnt), 32'h4);
    tick();
    chk("stall_cnt1", 32'(dut.cnt_q), 32'd1);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("stall_gnt_%0d", i), 32'(bus.gnt), 32'h4);
      chk($sformatf("stall_sel_%0d", i), 32'(bus.sel), 32'h2);
      chk($sformatf("stall_cnt_%0d", i), 32'(dut.cnt_q), 32'd1);
    end
    chk("stall_valid", 32'(bus.out_valid), 32'h1);
    bus.out_ready = 1'b1;
    tick();
    chk("stall_resume_cnt", 32'(dut.cnt_q), 32'd2);

    // Abandon: grant 1000, two beats, then req[3] drops.
    bus.req = 4'b1000;
    tick();
    chk("ab_pre_idle", 32'(bus.gnt), 32'h0);
    tick();
    chk("ab_gnt", 32'(bus.gnt), 32'h8);
    chk("ab_sel", 32'(bus.sel), 32'h3);
    tick(); tick();
    chk("ab_cnt2", 32'(dut.cnt_q), 32'd2);
    bus.req = 4'b0011;
    #1;
    chk("ab_valid_low", 32'(bus.out_valid), 32'h0);
    chk("ab_busy_hold", 32'(bus.busy), 32'h1);
    tick();
    chk("ab_release", 32'(bus.gnt), 32'h0);
    chk("ab_ptr", 32'(dut.ptr_q), 32'h0);
    tick();
    chk("ab_next_gnt", 32'(bus.gnt), 32'h1);

    // Reset during beat 3 of grant 0010.
    bus.req = 4'b0010;
    tick();
    chk("mr_pre_idle", 32'(bus.gnt), 32'h0);
    tick();
    chk("mr_gnt", 32'(bus.gnt), 32'h2);
    tick(); tick();
    chk("mr_cnt2", 32'(dut.cnt_q), 32'd2);
    rst = 1'b1;
    tick();
    chk("mr_gnt0", 32'(bus.gnt), 32'h0);
    chk("mr_busy0", 32'(bus.busy), 32'h0);
    chk("mr_valid0", 32'(bus.out_valid), 32'h0);
    chk("mr_sel0", 32'(bus.sel), 32'h0);
    chk("mr_cnt0", 32'(dut.cnt_q), 32'd0);
    chk("mr_ptr0", 32'(dut.ptr_q), 32'd0);
    rst = 1'b0; bus.req = 4'b1011;
    tick();
    chk("mr_restart", 32'(bus.gnt), 32'h1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
